// File: rtl/rr_arbiter_4_if.sv
// rr_arbiter_4_if
// Bundles the request/grant signals shared by the four requesters and the
// round-robin arbiter.
//   req        [3:0]  request vector, bit i = requester i wants the resource
//   done       [3:0]  completion strobe; only the bit of the current owner matters
//   gnt        [3:0]  one-hot grant, zero when idle
//   gnt_id     [1:0]  binary index of the current grant, zero when idle
//   gnt_valid         high while any grant is active
//   timeout           one-cycle pulse when a grant is force-released by the hold limit
//   timeout_id [1:0]  index of the force-released requester, meaningful with timeout
// Modports: master = requester side, slave = arbiter side.
interface rr_arbiter_4_if;
  logic [3:0] req;
  logic [3:0] done;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_valid;
  logic       timeout;
  logic [1:0] timeout_id;

  modport master (
    output req,
    output done,
    input  gnt,
    input  gnt_id,
    input  gnt_valid,
    input  timeout,
    input  timeout_id
  );

  modport slave (
    input  req,
    input  done,
    output gnt,
    output gnt_id,
    output gnt_valid,
    output timeout,
    output timeout_id
  );
endinterface

// File: rtl/rr_arbiter_4.sv
// rr_arbiter_4
// Four-requester round-robin arbiter for one shared datapath resource.
// A grant is held until the owner pulses done, withdraws its request, or
// reaches the MAX_HOLD cycle limit; priority then rotates starting just
// after the releasing owner so no requester starves.
// Parameters:
//   MAX_HOLD  maximum cycles a grant may be held (1..255), 0 = unlimited
// Ports:
//   clk    system clock, all state changes on the rising edge
//   reset  asynchronous, active-high reset
//   bus    rr_arbiter_4_if.slave (req/done in, gnt/gnt_id/gnt_valid/
//          timeout/timeout_id out, all outputs registered)
module rr_arbiter_4 #(
  parameter int MAX_HOLD = 16
) (
  input logic          clk,
  input logic          reset,
  rr_arbiter_4_if.slave bus
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic       HOLD_EN   = (MAX_HOLD != 0);
  localparam logic [7:0] HOLD_LAST = (MAX_HOLD == 0) ? 8'd0 : 8'(MAX_HOLD - 1);

  // Round-robin search: ptr+1, ptr+2, ptr+3, ptr (mod 4).
  // Result bit 2 = winner found, bits 1:0 = winner index.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] ptr);
    logic [1:0] i1;
    logic [1:0] i2;
    logic [1:0] i3;
    logic [2:0] res;
    i1 = ptr + 2'd1;
    i2 = ptr + 2'd2;
    i3 = ptr + 2'd3;
    if (r[i1]) begin
      res = {1'b1, i1};
    end else if (r[i2]) begin
      res = {1'b1, i2};
    end else if (r[i3]) begin
      res = {1'b1, i3};
    end else if (r[ptr]) begin
      res = {1'b1, ptr};
    end else begin
      res = 3'b000;
    end
    return res;
  endfunction

  // Binary index to one-hot vector.
  function automatic logic [3:0] onehot(input logic [1:0] idx);
    logic [3:0] v;
    case (idx)
      2'd0:    v = 4'b0001;
      2'd1:    v = 4'b0010;
      2'd2:    v = 4'b0100;
      2'd3:    v = 4'b1000;
      default: v = 4'b0000;
    endcase
    return v;
  endfunction

  state_t     state_r;
  logic [1:0] last_id_r;
  logic [7:0] hold_cnt_r;
  logic [3:0] gnt_r;
  logic [1:0] gnt_id_r;
  logic       gnt_valid_r;
  logic       timeout_r;
  logic [1:0] timeout_id_r;

  logic       rel_done_s;
  logic       rel_drop_s;
  logic       rel_limit_s;
  logic       release_s;
  logic       force_s;
  logic [1:0] ptr_s;
  logic [3:0] mask_s;
  logic [2:0] pick_s;

  // Release decode and same-cycle arbitration over the (possibly masked) requests.
  always_comb begin
    rel_done_s  = bus.done[gnt_id_r];
    rel_drop_s  = ~bus.req[gnt_id_r];
    rel_limit_s = HOLD_EN && (hold_cnt_r == HOLD_LAST);
    release_s   = (state_r == BUSY) && (rel_done_s || rel_drop_s || rel_limit_s);
    // Only a limit hit on an owner that still wants the resource and did not
    // finish counts as a forced release; done on the same cycle wins.
    force_s     = (state_r == BUSY) && rel_limit_s && !rel_done_s && !rel_drop_s;
    if (state_r == BUSY) begin
      ptr_s = gnt_id_r;
    end else begin
      ptr_s = last_id_r;
    end
    // A force-released owner sits out one arbitration so others get a turn.
    if (force_s) begin
      mask_s = ~onehot(gnt_id_r);
    end else begin
      mask_s = 4'b1111;
    end
    pick_s = rr_pick(bus.req & mask_s, ptr_s);
  end

  // Arbiter FSM with registered grant and timeout outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      last_id_r    <= 2'd3;
      hold_cnt_r   <= 8'd0;
      gnt_r        <= 4'b0000;
      gnt_id_r     <= 2'd0;
      gnt_valid_r  <= 1'b0;
      timeout_r    <= 1'b0;
      timeout_id_r <= 2'd0;
    end else begin
      timeout_r    <= 1'b0;
      timeout_id_r <= 2'd0;
      case (state_r)
        IDLE: begin
          if (pick_s[2]) begin
            state_r     <= BUSY;
            gnt_r       <= onehot(pick_s[1:0]);
            gnt_id_r    <= pick_s[1:0];
            gnt_valid_r <= 1'b1;
            last_id_r   <= pick_s[1:0];
            hold_cnt_r  <= 8'd0;
          end else begin
            state_r     <= IDLE;
            gnt_r       <= 4'b0000;
            gnt_id_r    <= 2'd0;
            gnt_valid_r <= 1'b0;
            hold_cnt_r  <= 8'd0;
          end
        end
        BUSY: begin
          if (release_s) begin
            if (force_s) begin
              timeout_r    <= 1'b1;
              timeout_id_r <= gnt_id_r;
            end else begin
              timeout_r    <= 1'b0;
              timeout_id_r <= 2'd0;
            end
            hold_cnt_r <= 8'd0;
            if (pick_s[2]) begin
              state_r     <= BUSY;
              gnt_r       <= onehot(pick_s[1:0]);
              gnt_id_r    <= pick_s[1:0];
              gnt_valid_r <= 1'b1;
              last_id_r   <= pick_s[1:0];
            end else begin
              state_r     <= IDLE;
              gnt_r       <= 4'b0000;
              gnt_id_r    <= 2'd0;
              gnt_valid_r <= 1'b0;
            end
          end else begin
            // Saturate so an unlimited grant never wraps the counter.
            if (hold_cnt_r != 8'hFF) begin
              hold_cnt_r <= hold_cnt_r + 8'd1;
            end else begin
              hold_cnt_r <= hold_cnt_r;
            end
          end
        end
        default: begin
          state_r     <= IDLE;
          gnt_r       <= 4'b0000;
          gnt_id_r    <= 2'd0;
          gnt_valid_r <= 1'b0;
          hold_cnt_r  <= 8'd0;
        end
      endcase
    end
  end

  assign bus.gnt        = gnt_r;
  assign bus.gnt_id     = gnt_id_r;
  assign bus.gnt_valid  = gnt_valid_r;
  assign bus.timeout    = timeout_r;
  assign bus.timeout_id = timeout_id_r;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// tb_rr_arbiter_4
// Directed bench for rr_arbiter_4: one instance with MAX_HOLD=16 and one with
// MAX_HOLD=0. Each step drives req/done, pushes the expected post-edge state
// onto a scoreboard queue, and pops/compares it one time unit after the edge.
module tb_rr_arbiter_4;

  logic clk;
  logic reset;

  rr_arbiter_4_if bus();
  rr_arbiter_4_if bus0();

  rr_arbiter_4 #(.MAX_HOLD(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  rr_arbiter_4 #(.MAX_HOLD(0)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         sel;
    logic [3:0] gnt;
    logic       to;
    logic [1:0] toid;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   checks;
  int   errors;

  function automatic logic [1:0] enc(input logic [3:0] g);
    case (g)
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic compare_front();
    exp_t       e;
    logic [3:0] og;
    logic [1:0] oid;
    logic       ov;
    logic       oto;
    logic [1:0] otid;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty: observed 0 entries expected 1");
    end else begin
      e = sb.pop_front();
      if (e.sel) begin
        og = bus0.gnt; oid = bus0.gnt_id; ov = bus0.gnt_valid;
        oto = bus0.timeout; otid = bus0.timeout_id;
      end else begin
        og = bus.gnt; oid = bus.gnt_id; ov = bus.gnt_valid;
        oto = bus.timeout; otid = bus.timeout_id;
      end
      check({e.tag, "_gnt"},       {4'b0, og},   {4'b0, e.gnt});
      check({e.tag, "_gnt_id"},    {6'b0, oid},  {6'b0, enc(e.gnt)});
      check({e.tag, "_gnt_valid"}, {7'b0, ov},   {7'b0, |e.gnt});
      check({e.tag, "_timeout"},   {7'b0, oto},  {7'b0, e.to});
      if (e.to) begin
        check({e.tag, "_timeout_id"}, {6'b0, otid}, {6'b0, e.toid});
      end
    end
  endtask

  task automatic step(input bit sel, input logic [3:0] r, input logic [3:0] d,
                      input logic [3:0] eg, input logic eto, input logic [1:0] etid,
                      input string tag);
    exp_t e;
    if (sel) begin
      bus0.req = r; bus0.done = d;
    end else begin
      bus.req = r; bus.done = d;
    end
    e.sel = sel; e.gnt = eg; e.to = eto; e.toid = etid; e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    compare_front();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.req = 4'b0;  bus.done = 4'b0;
    bus0.req = 4'b0; bus0.done = 4'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_gnt",        {4'b0, bus.gnt},        8'h00);
    check("rst_gnt_id",     {6'b0, bus.gnt_id},     8'h00);
    check("rst_gnt_valid",  {7'b0, bus.gnt_valid},  8'h00);
    check("rst_timeout",    {7'b0, bus.timeout},    8'h00);
    check("rst_timeout_id", {6'b0, bus.timeout_id}, 8'h00);
    reset = 1'b0;

    // Rotation with done on the 2nd granted cycle, no bubbles.
    step(1'b0, 4'b1111, 4'b0000, 4'b0001, 1'b0, 2'd0, "rot_g0a");
    step(1'b0, 4'b1111, 4'b0000, 4'b0001, 1'b0, 2'd0, "rot_g0b");
    step(1'b0, 4'b1111, 4'b0001, 4'b0010, 1'b0, 2'd0, "rot_g1a");
    step(1'b0, 4'b1111, 4'b0000, 4'b0010, 1'b0, 2'd0, "rot_g1b");
    step(1'b0, 4'b1111, 4'b0010, 4'b0100, 1'b0, 2'd0, "rot_g2a");
    step(1'b0, 4'b1111, 4'b0000, 4'b0100, 1'b0, 2'd0, "rot_g2b");
    step(1'b0, 4'b1111, 4'b0100, 4'b1000, 1'b0, 2'd0, "rot_g3a");
    step(1'b0, 4'b1111, 4'b0000, 4'b1000, 1'b0, 2'd0, "rot_g3b");
    step(1'b0, 4'b1111, 4'b1000, 4'b0001, 1'b0, 2'd0, "rot_g0c");
    step(1'b0, 4'b1111, 4'b0001, 4'b0010, 1'b0, 2'd0, "rot_g1c");
    step(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, "rot_idle");

    // Lone requester 2 held to the 16-cycle limit.
    step(1'b0, 4'b0100, 4'b0000, 4'b0100, 1'b0, 2'd0, "hold_first");
    for (int i = 0; i < 15; i++) begin
      step(1'b0, 4'b0100, 4'b0000, 4'b0100, 1'b0, 2'd0, "hold_keep");
    end
    step(1'b0, 4'b0100, 4'b0000, 4'b0000, 1'b1, 2'd2, "hold_timeout");
    step(1'b0, 4'b0100, 4'b0000, 4'b0100, 1'b0, 2'd0, "hold_regrant");
    step(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, "hold_idle");

    // Owner 1 drops its request; done[0] is not the owner's bit.
    step(1'b0, 4'b0010, 4'b0000, 4'b0010, 1'b0, 2'd0, "drop_g1");
    step(1'b0, 4'b1010, 4'b0001, 4'b0010, 1'b0, 2'd0, "drop_ign0a");
    step(1'b0, 4'b1010, 4'b0001, 4'b0010, 1'b0, 2'd0, "drop_ign0b");
    step(1'b0, 4'b1000, 4'b0001, 4'b1000, 1'b0, 2'd0, "drop_to3");
    step(1'b0, 4'b1000, 4'b0001, 4'b1000, 1'b0, 2'd0, "drop_ign0c");
    step(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, "drop_idle");

    // done coinciding with the hold limit counts as done.
    step(1'b0, 4'b0011, 4'b0000, 4'b0001, 1'b0, 2'd0, "coin_g0");
    for (int i = 0; i < 15; i++) begin
      step(1'b0, 4'b0011, 4'b0000, 4'b0001, 1'b0, 2'd0, "coin_keep");
    end
    step(1'b0, 4'b0011, 4'b0001, 4'b0010, 1'b0, 2'd0, "coin_done");
    step(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, "coin_idle");

    // Asynchronous reset in the middle of a grant.
    step(1'b0, 4'b0100, 4'b0000, 4'b0100, 1'b0, 2'd0, "arst_g2");
    reset = 1'b1;
    #2;
    check("arst_gnt",       {4'b0, bus.gnt},       8'h00);
    check("arst_gnt_id",    {6'b0, bus.gnt_id},    8'h00);
    check("arst_gnt_valid", {7'b0, bus.gnt_valid}, 8'h00);
    check("arst_timeout",   {7'b0, bus.timeout},   8'h00);
    bus.req = 4'b1100;
    @(posedge clk);
    #1;
    reset = 1'b0;
    step(1'b0, 4'b1100, 4'b0000, 4'b0100, 1'b0, 2'd0, "arst_first");
    step(1'b0, 4'b1100, 4'b0100, 4'b1000, 1'b0, 2'd0, "arst_next");
    step(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, "arst_idle");

    // Unlimited hold: grant persists 300 cycles, counter saturates.
    for (int i = 0; i < 300; i++) begin
      step(1'b1, 4'b0001, 4'b0000, 4'b0001, 1'b0, 2'd0, "nolim");
    end
    check("nolim_hold_cnt", dut0.hold_cnt_r, 8'hFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
